// File: rtl/latch_bank_arbiter_if.sv
// Write-request bus between up to three requesters and the latch bank arbiter,
// plus the latch-bank drive signals the arbiter produces.
interface latch_bank_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       req;
   logic [1:0]       waddr0;
   logic [1:0]       waddr1;
   logic [1:0]       waddr2;
   logic [WIDTH-1:0] wdata0;
   logic [WIDTH-1:0] wdata1;
   logic [WIDTH-1:0] wdata2;
   logic [2:0]       ack;
   logic [WIDTH-1:0] lat_d;
   logic [3:0]       lat_en;
   logic             busy;
   logic [1:0]       grant_id;

   modport master (
      output req, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2,
      input  ack, lat_d, lat_en, busy, grant_id
   );

   modport slave (
      input  req, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2,
      output ack, lat_d, lat_en, busy, grant_id
   );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter serialising three requesters onto a 4-entry latch bank.
// Each write: SETUP (data on bus), ENABLE for EN_CYC cycles, HOLD with ack.
module latch_bank_arbiter #(
   parameter int WIDTH  = 8,
   parameter int EN_CYC = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   latch_bank_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_e;

   localparam logic [3:0] CNT_LAST = 4'(EN_CYC - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       gid_q, gid_d;
   logic [1:0]       addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic [3:0]       lat_en_q, lat_en_d;
   logic [2:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [1:0]       grant_q, grant_d;

   logic [2:0][1:0]       waddr_a;
   logic [2:0][WIDTH-1:0] wdata_a;
   logic [1:0]            cand1, cand2, win;

   assign waddr_a = {bus.waddr2, bus.waddr1, bus.waddr0};
   assign wdata_a = {bus.wdata2, bus.wdata1, bus.wdata0};

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // ptr_q is the first requester searched; it always points one past the last grant.
   always_comb begin
      cand1 = inc3(ptr_q);
      cand2 = inc3(cand1);
      if (bus.req[ptr_q])      win = ptr_q;
      else if (bus.req[cand1]) win = cand1;
      else                     win = cand2;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gid_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic; request inputs are only looked at while idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = SETUP;
               gid_d   = win;
               addr_d  = waddr_a[win];
               data_d  = wdata_a[win];
               ptr_d   = inc3(win);
            end
         end
         SETUP: begin
            state_d = ENABLE;
            cnt_d   = '0;
         end
         ENABLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every output leaves a flop.
   always_comb begin
      busy_d   = (state_d != IDLE);
      grant_d  = busy_d ? gid_d : 2'd0;
      lat_en_d = (state_d == ENABLE) ? (4'b0001 << addr_d) : 4'b0000;
      ack_d    = (state_d == HOLD)   ? (3'b001 << gid_d)   : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_en_q <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
         grant_q  <= '0;
      end else begin
         lat_en_q <= lat_en_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         grant_q  <= grant_d;
      end
   end

   // data_q only changes on a grant, so it already holds its value through idle.
   assign bus.lat_d    = data_q;
   assign bus.lat_en   = lat_en_q;
   assign bus.ack      = ack_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Randomised and directed bench for latch_bank_arbiter against a write-timeline model.
module tb_latch_bank_arbiter;
   localparam int WIDTH  = 8;
   localparam int EN_CYC = 2;
   localparam int WLEN   = EN_CYC + 2;   // busy cycles per write

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   latch_bank_arbiter_if #(.WIDTH(WIDTH)) bus ();

   latch_bank_arbiter #(.WIDTH(WIDTH), .EN_CYC(EN_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: phase = cycles since the grant edge (0 = idle)
   int         m_phase = 0;
   int         m_ptr   = 0;
   int         m_gid   = 0;
   logic [1:0] m_addr  = '0;
   logic [7:0] m_data  = '0;
   logic [7:0] bank [4];
   int         cyc = 0;
   int         busy_cnt, en_cnt;
   logic [3:0] en_watch;
   bit         auto_drop = 1'b1;
   int         grants[$];
   int         gcyc[$];

   function automatic logic [1:0] req_addr(input int i);
      case (i)
         0:       return bus.waddr0;
         1:       return bus.waddr1;
         default: return bus.waddr2;
      endcase
   endfunction

   function automatic logic [7:0] req_data(input int i);
      case (i)
         0:       return bus.wdata0;
         1:       return bus.wdata1;
         default: return bus.wdata2;
      endcase
   endfunction

   task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
      case (i)
         0:       begin bus.waddr0 = a; bus.wdata0 = d; end
         1:       begin bus.waddr1 = a; bus.wdata1 = d; end
         default: begin bus.waddr2 = a; bus.wdata2 = d; end
      endcase
      bus.req[i] = 1'b1;
   endtask

   function automatic logic [31:0] exp_vec();
      logic       b;
      logic [1:0] g;
      logic [2:0] a;
      logic [3:0] e;
      b = (m_phase != 0);
      g = b ? 2'(m_gid) : 2'd0;
      e = (m_phase >= 2 && m_phase <= EN_CYC + 1) ? 4'(1 << m_addr) : 4'd0;
      a = (m_phase == WLEN) ? 3'(1 << m_gid) : 3'd0;
      return 32'({b, g, a, e, m_data});
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({bus.busy, bus.grant_id, bus.ack, bus.lat_en, bus.lat_d});
   endfunction

   // Advance the model across the next rising edge using the inputs now applied.
   task automatic m_step();
      if (m_phase == 0) begin
         if (bus.req != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
               int idx;
               idx = (m_ptr + k) % 3;
               if (m_phase == 0 && bus.req[idx]) begin
                  m_gid   = idx;
                  m_addr  = req_addr(idx);
                  m_data  = req_data(idx);
                  m_ptr   = (idx + 1) % 3;
                  m_phase = 1;
               end
            end
         end
      end else if (m_phase == WLEN) begin
         m_phase = 0;
      end else begin
         m_phase++;
      end
   endtask

   task automatic cycle();
      m_step();
      @(negedge clk);
      cyc++;
      chk("cyc", dut_vec(), exp_vec());
      chk("onehot0", 32'($onehot0(bus.lat_en)), 32'd1);
      if (bus.busy) busy_cnt++;
      if (bus.lat_en == en_watch && en_watch != 4'd0) en_cnt++;
      if (m_phase == 1) begin
         grants.push_back(int'(bus.grant_id));
         gcyc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) if (bus.lat_en[i]) bank[i] = bus.lat_d;
      if (auto_drop) for (int i = 0; i < 3; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.req = 3'b000;
      while (m_phase != 0 && n < 40) begin
         cycle();
         n++;
      end
      cycle();
      chk("drain_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_reset();
      bus.req = 3'b000;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      m_phase = 0;
      m_ptr   = 0;
      m_gid   = 0;
      m_addr  = '0;
      m_data  = '0;
      rst_n   = 1'b1;
      grants.delete();
      gcyc.delete();
      busy_cnt = 0;
      en_cnt   = 0;
      auto_drop = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.req = 3'b000;
      bus.waddr0 = '0; bus.waddr1 = '0; bus.waddr2 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
      for (int i = 0; i < 4; i++) bank[i] = '0;
      en_watch = 4'd0;

      // Reset state
      do_reset();
      chk("reset_outputs", dut_vec(), 32'd0);

      // Single write
      en_watch = 4'b0100;
      set_req(0, 2'd2, 8'hA5);
      run(8);
      chk("single_busy_cycles", 32'(busy_cnt), 32'd4);
      chk("single_en_cycles", 32'(en_cnt), 32'd2);
      chk("single_grants", 32'(grants.size()), 32'd1);
      chk("single_bank2", 32'(bank[2]), 32'hA5);
      chk("single_latd_held", 32'(bus.lat_d), 32'hA5);

      // Contention, each requester drops after its ack
      do_reset();
      set_req(0, 2'd0, 8'h10);
      set_req(1, 2'd1, 8'h21);
      set_req(2, 2'd2, 8'h32);
      run(16);
      chk("cont_count", 32'(grants.size()), 32'd3);
      for (int i = 0; i < grants.size() && i < 3; i++) chk("cont_order", 32'(grants[i]), 32'(i));
      for (int i = 1; i < gcyc.size(); i++) chk("cont_gap", 32'(gcyc[i] - gcyc[i-1]), 32'(WLEN + 1));
      chk("cont_bank1", 32'(bank[1]), 32'h21);

      // Fairness with req=011 held throughout
      do_reset();
      auto_drop = 1'b0;
      set_req(0, 2'd0, 8'h01);
      set_req(1, 2'd1, 8'h02);
      run(6 * (WLEN + 1));
      chk("fair_count", 32'(grants.size()), 32'd6);
      for (int i = 0; i < grants.size() && i < 6; i++) chk("fair_order", 32'(grants[i]), 32'(i % 2));
      auto_drop = 1'b1;
      drain();

      // Same-entry collision
      do_reset();
      set_req(0, 2'd3, 8'h11);
      set_req(1, 2'd3, 8'h22);
      run(12);
      chk("collide_order0", 32'(grants[0]), 32'd0);
      chk("collide_bank3", 32'(bank[3]), 32'h22);

      // Reset during the first ENABLE cycle
      do_reset();
      set_req(0, 2'd1, 8'h5A);
      run(2);
      chk("rst_pre_en", 32'(bus.lat_en), 32'b0010);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_en", 32'(bus.lat_en), 32'd0);
      chk("rst_async_ack", 32'(bus.ack), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      chk("rst_async_gid", 32'(bus.grant_id), 32'd0);
      m_phase = 0; m_ptr = 0; m_gid = 0; m_addr = '0; m_data = '0;
      grants.delete();
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 2'd0, 8'h77);
      set_req(1, 2'd1, 8'h88);
      set_req(2, 2'd2, 8'h99);
      cycle();
      chk("rst_next_grant", 32'(bus.grant_id), 32'd0);
      drain();

      // Inputs changed mid-transaction are ignored
      do_reset();
      set_req(0, 2'd0, 8'h3C);
      run(2);
      bus.waddr0 = 2'd3;
      bus.wdata0 = 8'hC3;
      cycle();
      chk("midchg_latd", 32'(bus.lat_d), 32'h3C);
      chk("midchg_en", 32'(bus.lat_en), 32'b0001);
      run(3);
      drain();

      // Randomised traffic with occasional mid-write drops and data churn
      do_reset();
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!bus.req[i] && $urandom_range(3) == 0)
               set_req(i, 2'($urandom_range(3)), 8'($urandom));
            else if (bus.req[i] && $urandom_range(7) == 0)
               set_req(i, 2'($urandom_range(3)), 8'($urandom));
            if (m_phase != 0 && m_gid == i && $urandom_range(9) == 0)
               bus.req[i] = 1'b0;
         end
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
